// File: rtl/dmem_pkg.sv
// Shared types and default sizes for the data memory reader.
package dmem_pkg;

  localparam int DMEM_DATA_W = 16;
  localparam int DMEM_ADDR_W = 8;
  localparam int CNT_W       = 4;   // covers WAIT_CYCLES up to 15

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RESP = 2'b10
  } dmem_state_t;

endpackage

// File: rtl/data_mem_reader_if.sv
// Store-path write port plus level-sensitive read request / ack bus.
interface data_mem_reader_if #(
  parameter int DATA_W = dmem_pkg::DMEM_DATA_W,
  parameter int ADDR_W = dmem_pkg::DMEM_ADDR_W
);
  logic              WrEn;
  logic [ADDR_W-1:0] WrAddr;
  logic [DATA_W-1:0] WrData;
  logic              RdReq;
  logic [ADDR_W-1:0] RdAddr;
  logic              Busy;
  logic              RdAck;
  logic [DATA_W-1:0] RdData;

  modport master (
    output WrEn, WrAddr, WrData, RdReq, RdAddr,
    input  Busy, RdAck, RdData
  );

  modport slave (
    input  WrEn, WrAddr, WrData, RdReq, RdAddr,
    output Busy, RdAck, RdData
  );
endinterface

// File: rtl/dmem_array.sv
// Storage array: synchronous write, combinational read, no reset on contents.
module dmem_array #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/data_mem_reader.sv
// Wait-stated read port over dmem_array. Define DMEM_RD_BYPASS_EN to forward a
// same-cycle write to the latched address into the read response.
module data_mem_reader
  import dmem_pkg::*;
#(
  parameter int          DATA_W      = DMEM_DATA_W,
  parameter int          ADDR_W      = DMEM_ADDR_W,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic             Clk,
  input  logic             Rst,
  data_mem_reader_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_LOAD =
    (WAIT_CYCLES == 0) ? '0 : CNT_W'(WAIT_CYCLES - 1);

  dmem_state_t       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              ack_q, ack_d;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] mem_rdata, rd_word;

  // Writes presented during reset are dropped, contents survive reset.
  dmem_array #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_array (
    .clk   (Clk),
    .we    (bus.WrEn & ~Rst),
    .waddr (bus.WrAddr),
    .wdata (bus.WrData),
    .raddr (addr_q),
    .rdata (mem_rdata)
  );

`ifdef DMEM_RD_BYPASS_EN
  assign rd_word = (bus.WrEn && (bus.WrAddr == addr_q)) ? bus.WrData : mem_rdata;
`else
  assign rd_word = mem_rdata;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    ack_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.RdReq) begin
          addr_d = bus.RdAddr;
          if (WAIT_CYCLES == 0) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_LOAD;
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) state_d = RESP;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      RESP: begin
        state_d = IDLE;
        ack_d   = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      ack_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      ack_q   <= ack_d;
      // Sample the word during the RESP cycle so WAIT-phase writes are seen.
      if (state_q == RESP) data_q <= rd_word;
    end
  end

  assign bus.Busy   = (state_q == WAIT) || (state_q == RESP);
  assign bus.RdAck  = ack_q;
  assign bus.RdData = data_q;

endmodule

// File: tb/tb_data_mem_reader.sv
// Directed bench: one reader with WAIT_CYCLES=2 (a) and one with 0 (b), shared writes.
module tb_data_mem_reader;

  logic Clk, Rst;
  int   n_vec, n_err;

  data_mem_reader_if #(.DATA_W(16), .ADDR_W(8)) a_if ();
  data_mem_reader_if #(.DATA_W(16), .ADDR_W(8)) b_if ();

  data_mem_reader #(.DATA_W(16), .ADDR_W(8), .WAIT_CYCLES(2)) u_a (
    .Clk(Clk), .Rst(Rst), .bus(a_if));
  data_mem_reader #(.DATA_W(16), .ADDR_W(8), .WAIT_CYCLES(0)) u_b (
    .Clk(Clk), .Rst(Rst), .bus(b_if));

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic [7:0]  wa;
    logic [15:0] wd;
    logic [7:0]  ra;
    logic [15:0] exp;
  } vec_t;

  vec_t vt [8];

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic wr(input logic [7:0] addr, input logic [15:0] data);
    a_if.WrEn = 1'b1; a_if.WrAddr = addr; a_if.WrData = data;
    b_if.WrEn = 1'b1; b_if.WrAddr = addr; b_if.WrData = data;
    tick();
    a_if.WrEn = 1'b0;
    b_if.WrEn = 1'b0;
  endtask

  // Read on the 2-wait-state instance; RdAddr is scrambled while busy.
  task automatic rd_a(input logic [7:0] addr, input logic [15:0] exp, input string nm);
    int lat, busy_n;
    lat = 0; busy_n = 0;
    a_if.RdReq = 1'b1; a_if.RdAddr = addr;
    tick();
    a_if.RdReq = 1'b0;
    while (!a_if.RdAck && lat < 20) begin
      busy_n += int'(a_if.Busy);
      a_if.RdAddr = a_if.RdAddr ^ 8'hFF;
      tick();
      lat++;
    end
    chk({nm, " latency"}, lat, 3);
    chk({nm, " busy cycles"}, busy_n, 3);
    chk({nm, " data"}, a_if.RdData, exp);
    tick();
    chk({nm, " ack pulse"}, a_if.RdAck, 0);
    chk({nm, " data held"}, a_if.RdData, exp);
  endtask

  initial begin
    logic [15:0] exp37;
    n_vec = 0; n_err = 0;
    Rst = 1'b1;
    a_if.WrEn = 0; a_if.WrAddr = 0; a_if.WrData = 0; a_if.RdReq = 0; a_if.RdAddr = 0;
    b_if.WrEn = 0; b_if.WrAddr = 0; b_if.WrData = 0; b_if.RdReq = 0; b_if.RdAddr = 0;

    vt[0] = '{8'h05, 16'h1234, 8'h05, 16'h1234};
    vt[1] = '{8'h00, 16'hFFFF, 8'h00, 16'hFFFF};
    vt[2] = '{8'hFF, 16'h8001, 8'hFF, 16'h8001};
    vt[3] = '{8'h10, 16'hAAAA, 8'h10, 16'hAAAA};
    vt[4] = '{8'h01, 16'h0101, 8'h01, 16'h0101};
    vt[5] = '{8'h02, 16'h0202, 8'h02, 16'h0202};
    vt[6] = '{8'h20, 16'h0000, 8'h05, 16'h1234};
    vt[7] = '{8'h30, 16'hBEEF, 8'hFF, 16'h8001};

    tick(); tick();
    chk("reset busy", a_if.Busy, 0);
    chk("reset ack", a_if.RdAck, 0);
    chk("reset data", a_if.RdData, 0);
    chk("reset busy b", b_if.Busy, 0);
    Rst = 1'b0;
    tick();

    for (int i = 0; i < 8; i++) begin
      wr(vt[i].wa, vt[i].wd);
      rd_a(vt[i].ra, vt[i].exp, $sformatf("vec%0d", i));
    end

    // Zero wait states, request held: acks on alternate cycles.
    b_if.RdReq = 1'b1; b_if.RdAddr = 8'h01;
    tick();
    b_if.RdAddr = 8'h02;
    chk("b0 busy", b_if.Busy, 1);
    chk("b0 ack early", b_if.RdAck, 0);
    tick();
    chk("b1 ack", b_if.RdAck, 1);
    chk("b1 data", b_if.RdData, 16'h0101);
    chk("b1 idle", b_if.Busy, 0);
    tick();
    chk("b2 gap ack", b_if.RdAck, 0);
    chk("b2 busy", b_if.Busy, 1);
    tick();
    b_if.RdReq = 1'b0;
    chk("b3 ack", b_if.RdAck, 1);
    chk("b3 data", b_if.RdData, 16'h0202);
    tick();
    chk("b4 ack", b_if.RdAck, 0);
    chk("b4 busy", b_if.Busy, 0);

    // Write to latched address during WAIT.
    a_if.RdReq = 1'b1; a_if.RdAddr = 8'h10;
    tick();
    a_if.RdReq = 1'b0;
    wr(8'h10, 16'h5555);
    tick();
    tick();
    chk("wait-write ack", a_if.RdAck, 1);
    chk("wait-write data", a_if.RdData, 16'h5555);
    wr(8'h10, 16'hAAAA);

    // Write to latched address in the RESP cycle.
`ifdef DMEM_RD_BYPASS_EN
    exp37 = 16'h5555;
`else
    exp37 = 16'hAAAA;
`endif
    a_if.RdReq = 1'b1; a_if.RdAddr = 8'h10;
    tick();
    a_if.RdReq = 1'b0;
    tick();
    tick();
    chk("resp-write busy", a_if.Busy, 1);
    wr(8'h10, 16'h5555);
    chk("resp-write ack", a_if.RdAck, 1);
    chk("resp-write data", a_if.RdData, exp37);
    rd_a(8'h10, 16'h5555, "resp-write mem");

    // Reset during WAIT; the write presented under reset must be dropped.
    a_if.RdReq = 1'b1; a_if.RdAddr = 8'h05;
    tick();
    a_if.RdReq = 1'b0;
    Rst = 1'b1;
    wr(8'h05, 16'hDEAD);
    Rst = 1'b0;
    chk("abort busy", a_if.Busy, 0);
    chk("abort data", a_if.RdData, 0);
    chk("abort ack", a_if.RdAck, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("abort no ack %0d", i), a_if.RdAck, 0);
    end
    rd_a(8'h05, 16'h1234, "post-reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/data_mem_reader.md
DATA_MEM_READER -- requirements
Module: data_mem_reader

Interface
REQ-001 The block SHALL provide parameter DATA_W, default 16, data word width in bits.
REQ-002 The block SHALL provide parameter ADDR_W, default 8, address width; memory depth is 2^ADDR_W words.
REQ-003 The block SHALL provide parameter WAIT_CYCLES, default 2, range 0..15, the number of wait states inserted before a read response.
REQ-004 Port Clk, input, 1: the single clock; all state updates on its rising edge.
REQ-005 Port Rst, input, 1: reset, synchronous and active-high.
REQ-006 Port WrEn, input, 1: write strobe from the datapath store path.
REQ-007 Port WrAddr, input, ADDR_W: write address.
REQ-008 Port WrData, input, DATA_W: write data.
REQ-009 Port RdReq, input, 1: read request, level-sensitive.
REQ-010 Port RdAddr, input, ADDR_W: read address, sampled only when a request is accepted.
REQ-011 Port Busy, output, 1: high while a read is in progress (WAIT or RESP).
REQ-012 Port RdAck, output, 1: single-cycle pulse marking RdData valid.
REQ-013 Port RdData, output, DATA_W: read result, held until the next RdAck.

Function
REQ-014 The FSM SHALL have three states: IDLE, WAIT and RESP.
REQ-015 In IDLE with RdReq=1, the block SHALL latch RdAddr and go to WAIT, or to RESP when WAIT_CYCLES=0.
REQ-016 In WAIT, a down-counter loaded with WAIT_CYCLES-1 SHALL decrement each cycle and move to RESP on the cycle it reads 0.
REQ-017 In RESP, RdAck SHALL be 1 for exactly one cycle, RdData SHALL equal mem[latched address] read in that cycle, and the next state SHALL be IDLE.
REQ-018 Latency from the accepting edge to RdAck high SHALL be WAIT_CYCLES+1 cycles.
REQ-019 RdReq and RdAddr SHALL be ignored outside IDLE; a request held high across an ack is accepted again in the following IDLE cycle, giving one idle cycle between transactions.
REQ-020 A write (WrEn=1) SHALL update mem[WrAddr] at the clock edge in every state, independent of the read FSM.
REQ-021 A write to the latched address during WAIT SHALL be visible in the RdData of that transaction.
REQ-022 A write to the latched address in the RESP cycle itself SHALL follow REQ-031.
REQ-023 Busy SHALL be 1 exactly when the state is WAIT or RESP.

Reset
REQ-024 With Rst=1 at an edge, the state SHALL become IDLE, the counter 0, Busy 0, RdAck 0 and RdData 0.
REQ-025 Reset mid-transaction SHALL abort the read with no RdAck issued.
REQ-026 Memory contents SHALL NOT be cleared by reset.
REQ-027 Writes presented while Rst=1 SHALL be discarded.

Configuration
REQ-028 Macro DMEM_RD_BYPASS_EN SHALL select same-cycle write-to-read forwarding.
REQ-029 With DMEM_RD_BYPASS_EN defined, a write to the latched address in the RESP cycle SHALL be forwarded, so RdData equals WrData.
REQ-030 Without DMEM_RD_BYPASS_EN, the block SHALL contain no forwarding logic.
REQ-031 In the REQ-022 case, RdData SHALL be WrData with the macro and the old memory word without it.

Structure
REQ-032 A shared package dmem_pkg SHALL hold the FSM state encoding (IDLE=2'b00, WAIT=2'b01, RESP=2'b10) and the default DATA_W and ADDR_W constants.
REQ-033 The storage array SHALL be one sub-module, dmem_array, with a synchronous write port and a combinational read port; the FSM, counter and bypass mux live in data_mem_reader.

Verification
REQ-034 Write mem[0x05]=0x1234, then pulse RdReq with RdAddr=0x05 (WAIT_CYCLES=2) -> RdAck high exactly 3 cycles after acceptance, RdData=0x1234, Busy high for 3 cycles.
REQ-035 WAIT_CYCLES=0, RdReq held high with addresses 0x01 then 0x02 -> acks on alternate cycles with the correct data, one idle cycle between them.
REQ-036 Read 0x10 (holding 0xAAAA) and write 0x10=0x5555 during WAIT -> RdData=0x5555.
REQ-037 Write 0x10=0x5555 in the RESP cycle of a read of 0x10 holding 0xAAAA -> RdData=0x5555 with DMEM_RD_BYPASS_EN, 0xAAAA without.
REQ-038 Assert Rst during WAIT -> no RdAck, and Busy=0, RdData=0 on the next cycle; prior mem contents still readable afterward.
REQ-039 Toggle RdAddr while Busy=1 -> the returned data matches the address latched at acceptance.
